// File: rtl/superh16_decode_queue_ctrl_if.sv
// -----------------------------------------------------------------------------
// superh16_decode_queue_ctrl_if
// Bundles the fetch-side, decode-side and control signals of the decode queue.
//   master : fetch/rename/control side (drives packets, dec_ready, flush)
//   slave  : the queue controller (drives fetch_ready, decoder lanes, occupancy)
// Signals:
//   flush        discard all queued and incoming instructions
//   fetch_valid  fetch packet present
//   fetch_ready  queue can accept a full packet this cycle
//   fetch_mask   per-lane valid mask of the fetch packet
//   fetch_inst   lane i at bits [32i+31:32i]
//   fetch_pc     PC of fetch lane 0
//   dec_valid    contiguous lane-valid vector to the decoders
//   dec_inst     instructions to decoder lanes
//   dec_pc       PCs to decoder lanes
//   dec_ready    rename accepts every presented lane
//   occupancy    current entry count
// -----------------------------------------------------------------------------
interface superh16_decode_queue_ctrl_if #(
   parameter int FETCH_WIDTH  = 4,
   parameter int DECODE_WIDTH = 4,
   parameter int DEPTH        = 16
);
   logic                        flush;
   logic                        fetch_valid;
   logic                        fetch_ready;
   logic [FETCH_WIDTH-1:0]      fetch_mask;
   logic [FETCH_WIDTH*32-1:0]   fetch_inst;
   logic [63:0]                 fetch_pc;
   logic [DECODE_WIDTH-1:0]     dec_valid;
   logic [DECODE_WIDTH*32-1:0]  dec_inst;
   logic [DECODE_WIDTH*64-1:0]  dec_pc;
   logic                        dec_ready;
   logic [$clog2(DEPTH):0]      occupancy;

   modport master (
      output flush, fetch_valid, fetch_mask, fetch_inst, fetch_pc, dec_ready,
      input  fetch_ready, dec_valid, dec_inst, dec_pc, occupancy
   );

   modport slave (
      input  flush, fetch_valid, fetch_mask, fetch_inst, fetch_pc, dec_ready,
      output fetch_ready, dec_valid, dec_inst, dec_pc, occupancy
   );
endinterface

// File: rtl/superh16_decode_queue_ctrl.sv
// -----------------------------------------------------------------------------
// superh16_decode_queue_ctrl
// Circular instruction buffer between fetch and the parallel decoder lanes.
// Fetch packets are compacted by lane mask into the queue; up to DECODE_WIDTH
// in-order entries are presented per cycle, with SYSTEM-opcode instructions
// issued alone in lane 0.
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset (priority over flush)
//   q      slave side of superh16_decode_queue_ctrl_if
// -----------------------------------------------------------------------------
module superh16_decode_queue_ctrl #(
   parameter int FETCH_WIDTH  = 4,
   parameter int DECODE_WIDTH = 4,
   parameter int DEPTH        = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   superh16_decode_queue_ctrl_if.slave   q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   function automatic logic f_is_system(input logic [31:0] inst);
      return inst[6:0] == OPC_SYSTEM;
   endfunction

   logic [31:0]             r_inst [DEPTH];
   logic [63:0]             r_pc   [DEPTH];
   logic [AW-1:0]           r_head;
   logic [AW-1:0]           r_tail;
   logic [CW-1:0]           r_count;

   logic                    w_enq;
   logic                    w_deq;
   logic [CW-1:0]           w_enq_cnt;
   logic [CW-1:0]           w_enq_eff;
   logic [CW-1:0]           w_deq_cnt;
   logic [AW-1:0]           w_off [FETCH_WIDTH];
   logic [CW-1:0]           w_k;
   logic                    w_stop;
   logic [AW-1:0]           w_idx;
   logic                    w_fetch_ready;
   logic [DECODE_WIDTH-1:0] w_dec_valid;
   logic [DECODE_WIDTH*32-1:0] w_dec_inst;
   logic [DECODE_WIDTH*64-1:0] w_dec_pc;

   // Room for a full packet, judged on registered count only
   assign w_fetch_ready = (r_count <= CW'(DEPTH - FETCH_WIDTH));

   // Per-lane write offset = number of set mask bits below that lane
   always_comb begin
      w_enq_cnt = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         w_off[i] = w_enq_cnt[AW-1:0];
         if (q.fetch_mask[i]) begin
            w_enq_cnt = w_enq_cnt + CW'(1);
         end else begin
            w_enq_cnt = w_enq_cnt;
         end
      end
   end

   // Count of entries presented: stop before the first SYSTEM entry unless it is at head
   always_comb begin
      w_k    = '0;
      w_stop = 1'b0;
      w_idx  = r_head;
      for (int j = 0; j < DECODE_WIDTH; j++) begin
         w_idx = r_head + AW'(j);
         if (!w_stop && (CW'(j) < r_count)) begin
            if (f_is_system(r_inst[w_idx])) begin
               w_stop = 1'b1;
               if (j == 0) begin
                  w_k = CW'(1);
               end else begin
                  w_k = w_k;
               end
            end else begin
               w_k = CW'(j + 1);
            end
         end else begin
            w_stop = 1'b1;
         end
      end
   end

   // Decoder lane outputs; unpresented lanes drive zero
   always_comb begin
      w_dec_valid = '0;
      w_dec_inst  = '0;
      w_dec_pc    = '0;
      for (int j = 0; j < DECODE_WIDTH; j++) begin
         if (CW'(j) < w_k) begin
            w_dec_valid[j]       = 1'b1;
            w_dec_inst[j*32 +: 32] = r_inst[r_head + AW'(j)];
            w_dec_pc[j*64 +: 64]   = r_pc[r_head + AW'(j)];
         end else begin
            w_dec_valid[j] = 1'b0;
         end
      end
   end

   assign w_enq     = q.fetch_valid && w_fetch_ready && !q.flush;
   assign w_deq     = q.dec_ready && (|w_dec_valid) && !q.flush;
   assign w_enq_eff = w_enq ? w_enq_cnt : '0;
   assign w_deq_cnt = w_deq ? w_k : '0;

   // Pointer and count state
   always_ff @(posedge i_clk) begin
      if (i_rst || q.flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_tail  <= r_tail + w_enq_eff[AW-1:0];
         r_head  <= r_head + w_deq_cnt[AW-1:0];
         r_count <= r_count + w_enq_eff - w_deq_cnt;
      end
   end

   // Entry storage: compacted write of masked lanes at tail onward (wraps naturally)
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (w_enq && q.fetch_mask[i]) begin
            r_inst[r_tail + w_off[i]] <= q.fetch_inst[32*i +: 32];
            r_pc[r_tail + w_off[i]]   <= q.fetch_pc + 64'(4 * i);
         end
      end
   end

   assign q.fetch_ready = w_fetch_ready;
   assign q.dec_valid   = w_dec_valid;
   assign q.dec_inst    = w_dec_inst;
   assign q.dec_pc      = w_dec_pc;
   assign q.occupancy   = r_count;

   superh16_decode_queue_ctrl_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_count   (r_count),
      .i_enq_cnt (w_enq_eff),
      .i_deq_cnt (w_deq_cnt)
   );
endmodule

// -----------------------------------------------------------------------------
// superh16_decode_queue_ctrl_chk
// Occupancy bound, overflow and underflow properties of the decode queue.
// -----------------------------------------------------------------------------
module superh16_decode_queue_ctrl_chk #(
   parameter int DEPTH = 16,
   parameter int CW    = 5
) (
   input logic          i_clk,
   input logic          i_rst,
   input logic [CW-1:0] i_count,
   input logic [CW-1:0] i_enq_cnt,
   input logic [CW-1:0] i_deq_cnt
);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   a_count_max: assert property (@(posedge i_clk) disable iff (i_rst)
      {1'b0, i_count} <= DEPTH_W);
   a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
      i_deq_cnt <= i_count);
   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      ({1'b0, i_count} + {1'b0, i_enq_cnt}) <= (DEPTH_W + {1'b0, i_deq_cnt}));
endmodule

// File: tb/tb_superh16_decode_queue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_superh16_decode_queue_ctrl
// Directed bench: a vector table for reset/single/sparse/empty behaviour, then
// hand-written sequences for SYSTEM serialization, full/wrap streaming, flush
// and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_superh16_decode_queue_ctrl;
   localparam int FW = 4;
   localparam int DW = 4;
   localparam int D  = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   superh16_decode_queue_ctrl_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(D)) qif ();

   superh16_decode_queue_ctrl #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(D)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .q     (qif)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic            fl;
      logic            fv;
      logic [3:0]      m;
      logic [63:0]     pc;
      logic            dr;
      logic [3:0]      ev;
      logic [4:0]      eocc;
      logic            efr;
      logic [3:0][63:0] epc;
   } vec_t;

   vec_t tbl [9];
   logic [63:0] mq [$];
   logic [63:0] pcn;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [63:0] pc);
      return {pc[24:0], 7'b0010011};
   endfunction

   function automatic logic [3:0][63:0] pcs(input logic [63:0] a, b, c, d);
      logic [3:0][63:0] r;
      r[0] = a; r[1] = b; r[2] = c; r[3] = d;
      return r;
   endfunction

   task automatic drive(input logic fl, input logic fv, input logic [3:0] m,
                        input logic [63:0] pc, input logic dr);
      qif.flush       = fl;
      qif.fetch_valid = fv;
      qif.fetch_mask  = m;
      qif.fetch_pc    = pc;
      qif.dec_ready   = dr;
      for (int i = 0; i < FW; i++) qif.fetch_inst[32*i +: 32] = mk(pc + 64'(4 * i));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare presented lanes against expected PCs (instruction derived from PC)
   task automatic chk_lanes(input string name, input logic [3:0] ev, input logic [3:0][63:0] epc);
      chk({name, "_valid"}, 64'(qif.dec_valid), 64'(ev));
      for (int j = 0; j < DW; j++) begin
         if (ev[j]) begin
            chk($sformatf("%s_pc%0d", name, j), qif.dec_pc[64*j +: 64], epc[j]);
            chk($sformatf("%s_inst%0d", name, j), 64'(qif.dec_inst[32*j +: 32]), 64'(mk(epc[j])));
         end
      end
   endtask

   initial begin
      // flush fv  mask   pc          dr  ev    occ  fr  lane PCs
      tbl[0] = '{1'b0, 1'b0, 4'h0, 64'h0,    1'b0, 4'h0, 5'd0, 1'b1, pcs(64'h0, 64'h0, 64'h0, 64'h0)};
      tbl[1] = '{1'b0, 1'b1, 4'hF, 64'h1000, 1'b0, 4'h0, 5'd0, 1'b1, pcs(64'h0, 64'h0, 64'h0, 64'h0)};
      tbl[2] = '{1'b0, 1'b0, 4'h0, 64'h0,    1'b0, 4'hF, 5'd4, 1'b1, pcs(64'h1000, 64'h1004, 64'h1008, 64'h100C)};
      tbl[3] = '{1'b0, 1'b0, 4'h0, 64'h0,    1'b1, 4'hF, 5'd4, 1'b1, pcs(64'h1000, 64'h1004, 64'h1008, 64'h100C)};
      tbl[4] = '{1'b0, 1'b1, 4'hA, 64'h2000, 1'b1, 4'h0, 5'd0, 1'b1, pcs(64'h0, 64'h0, 64'h0, 64'h0)};
      tbl[5] = '{1'b0, 1'b0, 4'h0, 64'h0,    1'b0, 4'h3, 5'd2, 1'b1, pcs(64'h2004, 64'h200C, 64'h0, 64'h0)};
      tbl[6] = '{1'b0, 1'b0, 4'h0, 64'h0,    1'b1, 4'h3, 5'd2, 1'b1, pcs(64'h2004, 64'h200C, 64'h0, 64'h0)};
      tbl[7] = '{1'b0, 1'b1, 4'h0, 64'h5000, 1'b0, 4'h0, 5'd0, 1'b1, pcs(64'h0, 64'h0, 64'h0, 64'h0)};
      tbl[8] = '{1'b0, 1'b0, 4'h0, 64'h0,    1'b0, 4'h0, 5'd0, 1'b1, pcs(64'h0, 64'h0, 64'h0, 64'h0)};

      // Reset for two cycles, checked while still in reset
      rst = 1'b1;
      drive(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
      step();
      step();
      chk("rst_valid", 64'(qif.dec_valid), 64'h0);
      chk("rst_occ",   64'(qif.occupancy), 64'h0);
      chk("rst_fr",    64'(qif.fetch_ready), 64'h1);
      rst = 1'b0;

      // Vector table: outputs checked against state before the edge of each vector
      for (int v = 0; v < 9; v++) begin
         drive(tbl[v].fl, tbl[v].fv, tbl[v].m, tbl[v].pc, tbl[v].dr);
         #1;
         chk_lanes($sformatf("vec%0d", v), tbl[v].ev, tbl[v].epc);
         chk($sformatf("vec%0d_occ", v), 64'(qif.occupancy), 64'(tbl[v].eocc));
         chk($sformatf("vec%0d_fr", v), 64'(qif.fetch_ready), 64'(tbl[v].efr));
         @(posedge clk);
         #1;
      end

      // SYSTEM serialization: {ADDI, ECALL, ADDI, ADDI}
      drive(1'b0, 1'b1, 4'hF, 64'h4000, 1'b0);
      qif.fetch_inst[63:32] = 32'h00000073;
      step();
      drive(1'b0, 1'b0, 4'h0, 64'h0, 1'b1);
      #1;
      chk_lanes("sys_c1", 4'h1, pcs(64'h4000, 64'h0, 64'h0, 64'h0));
      chk("sys_c1_occ", 64'(qif.occupancy), 64'd4);
      step();
      chk("sys_c2_valid", 64'(qif.dec_valid), 64'h1);
      chk("sys_c2_pc", qif.dec_pc[63:0], 64'h4004);
      chk("sys_c2_inst", 64'(qif.dec_inst[31:0]), 64'h73);
      chk("sys_c2_occ", 64'(qif.occupancy), 64'd3);
      step();
      chk_lanes("sys_c3", 4'h3, pcs(64'h4008, 64'h400C, 64'h0, 64'h0));
      step();
      chk("sys_end_occ", 64'(qif.occupancy), 64'd0);

      // Fill to full with rename stalled
      pcn = 64'h8000;
      for (int p = 0; p < 4; p++) begin
         drive(1'b0, 1'b1, 4'hF, pcn, 1'b0);
         #1;
         chk($sformatf("fill%0d_fr", p), 64'(qif.fetch_ready), 64'h1);
         chk($sformatf("fill%0d_occ", p), 64'(qif.occupancy), 64'(4 * p));
         step();
         for (int i = 0; i < 4; i++) mq.push_back(pcn + 64'(4 * i));
         pcn = pcn + 64'h10;
      end
      drive(1'b0, 1'b1, 4'hF, pcn, 1'b0);
      #1;
      chk("full_fr", 64'(qif.fetch_ready), 64'h0);
      chk("full_occ", 64'(qif.occupancy), 64'd16);
      step();
      chk("full_hold_occ", 64'(qif.occupancy), 64'd16);

      // Stream with simultaneous enqueue/dequeue across the wrap point
      for (int c = 0; c < 20; c++) begin
         logic exp_fr;
         drive(1'b0, 1'b1, 4'hF, pcn, 1'b1);
         #1;
         exp_fr = ((D - mq.size()) >= FW);
         chk($sformatf("strm%0d_fr", c), 64'(qif.fetch_ready), 64'(exp_fr));
         chk($sformatf("strm%0d_occ", c), 64'(qif.occupancy), 64'(mq.size()));
         chk_lanes($sformatf("strm%0d", c), 4'hF, pcs(mq[0], mq[1], mq[2], mq[3]));
         step();
         for (int i = 0; i < 4; i++) void'(mq.pop_front());
         if (exp_fr) begin
            for (int i = 0; i < 4; i++) mq.push_back(pcn + 64'(4 * i));
            pcn = pcn + 64'h10;
         end
      end
      chk("strm_post_occ", 64'(qif.occupancy), 64'(mq.size()));

      // Drain and confirm no loss or duplication
      for (int c = 0; c < 5; c++) begin
         logic [3:0] ev;
         logic [3:0][63:0] epc;
         int n;
         n   = (mq.size() >= 4) ? 4 : mq.size();
         ev  = 4'((1 << n) - 1);
         epc = '0;
         for (int j = 0; j < n; j++) epc[j] = mq[j];
         drive(1'b0, 1'b0, 4'h0, 64'h0, 1'b1);
         #1;
         chk_lanes($sformatf("drain%0d", c), ev, epc);
         step();
         for (int j = 0; j < n; j++) void'(mq.pop_front());
      end
      chk("drain_occ", 64'(qif.occupancy), 64'd0);

      // Flush mid-stream at count 9 with fetch and rename both active
      drive(1'b0, 1'b1, 4'hF, 64'h9000, 1'b0); step();
      drive(1'b0, 1'b1, 4'hF, 64'h9010, 1'b0); step();
      drive(1'b0, 1'b1, 4'h1, 64'h9020, 1'b0); step();
      drive(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
      #1;
      chk("preflush_occ", 64'(qif.occupancy), 64'd9);
      drive(1'b1, 1'b1, 4'hF, 64'hA000, 1'b1);
      step();
      drive(1'b0, 1'b0, 4'h0, 64'h0, 1'b1);
      #1;
      chk("flush_occ", 64'(qif.occupancy), 64'd0);
      chk("flush_valid", 64'(qif.dec_valid), 64'h0);
      chk("flush_fr", 64'(qif.fetch_ready), 64'h1);
      drive(1'b0, 1'b1, 4'hF, 64'h3000, 1'b0);
      step();
      drive(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
      #1;
      chk_lanes("postflush", 4'hF, pcs(64'h3000, 64'h3004, 64'h3008, 64'h300C));
      chk("postflush_occ", 64'(qif.occupancy), 64'd4);

      // Reset mid-stream, asserted together with flush
      rst = 1'b1;
      drive(1'b1, 1'b1, 4'hF, 64'hB000, 1'b0);
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
      #1;
      chk("rst2_occ", 64'(qif.occupancy), 64'd0);
      chk("rst2_valid", 64'(qif.dec_valid), 64'h0);
      chk("rst2_fr", 64'(qif.fetch_ready), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
